regfile32_rd: RTL and testbench

REGFILE32_RD -- requirements
Module: regfile32_rd

---
 rtl/regfile32_rd.sv | 112 +++++++++++
 tb/tb_regfile32_rd.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/regfile32_rd.sv
// ---------------------------------------------------------------------------
// regfile32_rd : 32-entry register file, one-hot write, two 1-cycle read ports
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile32_rd #(
  parameter int WIDTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ra_req,
  input  logic [4:0]       ra_addr,
  output logic             ra_valid,
  output logic [WIDTH-1:0] ra_data,
  input  logic             rb_req,
  input  logic [4:0]       rb_addr,
  output logic             rb_valid,
  output logic [WIDTH-1:0] rb_data,
  input  logic             err_clr,
  output logic             err
);

  localparam int NUM_ENTRIES = 32;
  localparam int NUM_PORTS   = 2;

  logic [WIDTH-1:0] mem [NUM_ENTRIES];

  logic             wen_any;
  logic             wen_multi;
  logic             wen_zero_only;
  logic             write_ok;
  logic [4:0]       widx;

  // A multi-hot vector has some bit left set after clearing its lowest one.
  assign wen_any       = |wen;
  assign wen_multi     = |(wen & 32'(wen - 32'd1));
  assign wen_zero_only = (ZERO_REG != 0) && (wen == 32'h0000_0001);
  assign write_ok      = wen_any && !wen_multi && !wen_zero_only;

  always_comb begin
    widx = 5'd0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (wen[i]) widx = widx | 5'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) mem[i] <= '0;
    end else if (write_ok) begin
      mem[widx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (wen_multi) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  logic             req_p   [NUM_PORTS];
  logic [4:0]       addr_p  [NUM_PORTS];
  logic             valid_p [NUM_PORTS];
  logic [WIDTH-1:0] data_p  [NUM_PORTS];

  assign req_p[0]  = ra_req;
  assign req_p[1]  = rb_req;
  assign addr_p[0] = ra_addr;
  assign addr_p[1] = rb_addr;
  assign ra_valid  = valid_p[0];
  assign rb_valid  = valid_p[1];
  assign ra_data   = data_p[0];
  assign rb_data   = data_p[1];

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [WIDTH-1:0] rd_value;

      // Entry 0 is forced to zero ahead of the bypass so a same-cycle write cannot leak through.
      always_comb begin
        if ((ZERO_REG != 0) && (addr_p[p] == 5'd0)) begin
          rd_value = '0;
        end else if (write_ok && (widx == addr_p[p])) begin
          rd_value = wdata;
        end else begin
          rd_value = mem[addr_p[p]];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_p[p] <= 1'b0;
          data_p[p]  <= '0;
        end else begin
          valid_p[p] <= req_p[p];
          if (req_p[p]) data_p[p] <= rd_value;
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile32_rd.sv
// ---------------------------------------------------------------------------
// tb_regfile32_rd : directed self-checking bench for regfile32_rd
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile32_rd;

  logic        clk;
  logic        rst_n;
  logic [31:0] wen;
  logic [31:0] wdata;
  logic        ra_req;
  logic [4:0]  ra_addr;
  logic        ra_valid;
  logic [31:0] ra_data;
  logic        rb_req;
  logic [4:0]  rb_addr;
  logic        rb_valid;
  logic [31:0] rb_data;
  logic        err_clr;
  logic        err;

  int total;
  int bad;

  regfile32_rd #(.WIDTH(32), .ZERO_REG(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wen      (wen),
    .wdata    (wdata),
    .ra_req   (ra_req),
    .ra_addr  (ra_addr),
    .ra_valid (ra_valid),
    .ra_data  (ra_data),
    .rb_req   (rb_req),
    .rb_addr  (rb_addr),
    .rb_valid (rb_valid),
    .rb_data  (rb_data),
    .err_clr  (err_clr),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = '0; wdata = '0; ra_req = 0; ra_addr = '0; rb_req = 0; rb_addr = '0; err_clr = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #2;
    total++; if (ra_valid !== 1'b0 || rb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid ra=%b rb=%b exp 0", ra_valid, rb_valid); end
    total++; if (ra_data !== 32'h0 || rb_data !== 32'h0) begin bad++; $display("FAIL reset_data ra=%h rb=%h exp 0", ra_data, rb_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp 0", err); end
    ra_req = 1; rb_req = 1; wen = 32'h0000_0006;
    tick();
    total++; if (ra_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL req_in_reset valid=%b err=%b exp 0 0", ra_valid, err); end
    idle();
    rst_n = 1;
    tick();
    total++; if (ra_valid !== 1'b0 || rb_valid !== 1'b0) begin bad++; $display("FAIL post_release_valid ra=%b rb=%b exp 0", ra_valid, rb_valid); end
  endtask

  task automatic test_read_after_reset();
    ra_req = 1; ra_addr = 5'd5;
    tick();
    total++; if (ra_valid !== 1'b1 || ra_data !== 32'h0) begin bad++; $display("FAIL read5 valid=%b data=%h exp 1 00000000", ra_valid, ra_data); end
    idle();
    tick();
    total++; if (ra_valid !== 1'b0) begin bad++; $display("FAIL read5_single valid=%b exp 0", ra_valid); end
  endtask

  task automatic test_bypass();
    wen = 32'h0000_0008; wdata = 32'hDEAD_BEEF; rb_req = 1; rb_addr = 5'd3;
    tick();
    total++; if (rb_valid !== 1'b1 || rb_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass3 valid=%b data=%h exp 1 deadbeef", rb_valid, rb_data); end
    wen = '0; ra_req = 1; ra_addr = 5'd3;
    tick();
    total++; if (rb_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL stored3 data=%h exp deadbeef", rb_data); end
    total++; if (ra_valid !== 1'b1 || ra_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL same_addr_a valid=%b data=%h exp 1 deadbeef", ra_valid, ra_data); end
    // write entry 7, then read it on A while writing entry 8 with a B bypass
    wen = 32'h0000_0080; wdata = 32'h0F0F_0F0F; ra_req = 0; rb_req = 0;
    tick();
    wen = 32'h0000_0100; wdata = 32'h7777_1111; ra_req = 1; ra_addr = 5'd7; rb_req = 1; rb_addr = 5'd8;
    tick();
    total++; if (ra_data !== 32'h0F0F_0F0F) begin bad++; $display("FAIL read7 data=%h exp 0f0f0f0f", ra_data); end
    total++; if (rb_data !== 32'h7777_1111) begin bad++; $display("FAIL bypass8 data=%h exp 77771111", rb_data); end
    idle();
    tick();
  endtask

  task automatic test_multihot();
    wen = 32'h0000_0006; wdata = 32'h0000_1234; ra_req = 1; ra_addr = 5'd1;
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL multihot_err got=%b exp 1", err); end
    total++; if (ra_data !== 32'h0) begin bad++; $display("FAIL multihot_nobypass data=%h exp 0", ra_data); end
    wen = '0; ra_addr = 5'd1; rb_req = 1; rb_addr = 5'd2;
    tick();
    total++; if (ra_data !== 32'h0 || rb_data !== 32'h0) begin bad++; $display("FAIL multihot_nowrite e1=%h e2=%h exp 0 0", ra_data, rb_data); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp 1", err); end
    idle(); err_clr = 1;
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clr got=%b exp 0", err); end
    err_clr = 1; wen = 32'h0000_0030; wdata = 32'h5555_5555;
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp 1", err); end
    idle(); ra_req = 1; ra_addr = 5'd4; rb_req = 1; rb_addr = 5'd5;
    tick();
    total++; if (ra_data !== 32'h0 || rb_data !== 32'h0) begin bad++; $display("FAIL multihot30_nowrite e4=%h e5=%h exp 0 0", ra_data, rb_data); end
    idle(); err_clr = 1;
    tick();
    idle();
  endtask

  task automatic test_zero_reg();
    wen = 32'h0000_0001; wdata = 32'hFFFF_FFFF; ra_req = 1; ra_addr = 5'd0; rb_req = 1; rb_addr = 5'd0;
    tick();
    total++; if (ra_valid !== 1'b1 || ra_data !== 32'h0) begin bad++; $display("FAIL zero_a valid=%b data=%h exp 1 0", ra_valid, ra_data); end
    total++; if (rb_valid !== 1'b1 || rb_data !== 32'h0) begin bad++; $display("FAIL zero_b valid=%b data=%h exp 1 0", rb_valid, rb_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL zero_err got=%b exp 0", err); end
    wen = '0;
    tick();
    total++; if (ra_data !== 32'h0) begin bad++; $display("FAIL zero_stored data=%h exp 0", ra_data); end
    wen = 32'h0000_0003; wdata = 32'hCAFE_0001; ra_addr = 5'd1; rb_req = 0;
    tick();
    total++; if (err !== 1'b1 || ra_data !== 32'h0) begin bad++; $display("FAIL zero_multihot err=%b e1=%h exp 1 0", err, ra_data); end
    idle(); err_clr = 1;
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    wen = 32'h8000_0000; wdata = 32'hA5A5_A5A5;
    tick();
    idle(); ra_req = 1; ra_addr = 5'd31;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (ra_valid !== 1'b1 || ra_data !== 32'hA5A5_A5A5) begin bad++; $display("FAIL b2b_%0d valid=%b data=%h exp 1 a5a5a5a5", k, ra_valid, ra_data); end
    end
    ra_req = 0;
    tick();
    total++; if (ra_valid !== 1'b0 || ra_data !== 32'hA5A5_A5A5) begin bad++; $display("FAIL drop_hold valid=%b data=%h exp 0 a5a5a5a5", ra_valid, ra_data); end
    rst_n = 0;
    #1;
    total++; if (ra_valid !== 1'b0 || ra_data !== 32'h0) begin bad++; $display("FAIL async_rst valid=%b data=%h exp 0 0", ra_valid, ra_data); end
    rst_n = 1;
    ra_req = 1; ra_addr = 5'd31;
    tick();
    total++; if (ra_valid !== 1'b1 || ra_data !== 32'h0) begin bad++; $display("FAIL mem_cleared valid=%b data=%h exp 1 0", ra_valid, ra_data); end
    ra_req = 0;
    #2 rst_n = 0;
    #1;
    total++; if (ra_valid !== 1'b0) begin bad++; $display("FAIL pending_cleared valid=%b exp 0", ra_valid); end
    rst_n = 1;
    tick();
    total++; if (ra_valid !== 1'b0) begin bad++; $display("FAIL no_pulse_after valid=%b exp 0", ra_valid); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_read_after_reset();
    test_bypass();
    test_multihot();
    test_zero_reg();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
